// File: rtl/pc_pkg.sv
// Shared types for the fetch PC generator: FSM states, next-PC sources and
// a small sizing helper used by the return-address stack.
package pc_pkg;

  typedef enum logic {
    StBoot,
    StRun
  } pc_state_e;

  typedef enum logic [2:0] {
    SrcTrap,
    SrcRedirect,
    SrcRas,
    SrcSeq,
    SrcHold
  } pc_src_e;

  // Width of an index into a table of 'depth' entries (at least 1 bit).
  function automatic int unsigned idx_width(int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; push together with pop on a non-empty stack replaces the top.
// clear empties the stack logically without touching the entries.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  input  logic            clear,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PtrW = idx_width(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] entries_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d, ptr_prev, ptr_next, wr_idx;
  logic [CntW-1:0] count_q, count_d;
  logic            replace, do_push, do_pop, do_write;

  // Pointer arithmetic, status flags and operation decode.
  always_comb begin
    ptr_prev = (ptr_q == '0) ? PtrW'(RAS_DEPTH - 1) : ptr_q - PtrW'(1);
    ptr_next = (ptr_q == PtrW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PtrW'(1);
    empty    = (count_q == '0);
    full     = (count_q == CntW'(RAS_DEPTH));
    top      = entries_q[ptr_prev];
    replace  = push & pop & ~empty;
    do_push  = push & ~replace;
    do_pop   = pop & ~push & ~empty;
    do_write = (do_push | replace) & ~clear;
    wr_idx   = replace ? ptr_prev : ptr_q;
  end

  // Next pointer and occupancy count.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (do_push) begin
      ptr_d   = ptr_next;
      count_d = full ? count_q : count_q + CntW'(1);
    end else if (do_pop) begin
      ptr_d   = ptr_prev;
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are never reset, only the count is.
  always_ff @(posedge clk) begin
    if (do_write) begin
      entries_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > redirect > RAS return > sequential > hold.
// Optional return-address stack enabled with macro PC_GEN_RAS_EN; without it
// pred_call/pred_ret are ignored and ras_hit stays 0.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int unsigned     INST_BYTES   = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            pred_call,
  input  logic            pred_ret,
  input  logic            req_ready,
  output logic            req_valid,
  output logic [XLEN-1:0] current_pc,
  output logic            ras_hit
);

  localparam logic [XLEN-1:0] AlignMask = ~(XLEN'(INST_BYTES - 1));

  pc_state_e       state_q, state_d;
  pc_src_e         src;
  logic [XLEN-1:0] pc_q, pc_d, pc_seq;
  logic            ras_hit_q;
  logic            handshake;
  logic            ras_take;
  logic [XLEN-1:0] ras_top;

  assign pc_seq = pc_q + XLEN'(INST_BYTES);

`ifdef PC_GEN_RAS_EN
  logic ras_empty, ras_full, ras_push, ras_pop, redirect_any;

  assign redirect_any = trap_valid | redirect_valid;
  assign ras_take     = handshake & pred_ret & ~ras_empty;
  // Redirect cycles never touch the stack; a trap also empties it.
  assign ras_push     = handshake & pred_call & ~redirect_any;
  assign ras_pop      = handshake & pred_ret & ~redirect_any;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .clear     (trap_valid),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  logic unused_ras_full;
  assign unused_ras_full = ras_full;
`else
  logic unused_pred;
  assign unused_pred = pred_call ^ pred_ret;
  assign ras_take    = 1'b0;
  assign ras_top     = '0;
`endif

  // FSM next state and fetch-valid output.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        state_d   = StRun;
        req_valid = ~stall;
      end
      default: state_d = StBoot;
    endcase
  end

  assign handshake = req_valid & req_ready;

  // Next-PC source selection by priority, then the PC mux.
  always_comb begin
    src = SrcHold;
    if (trap_valid) begin
      src = SrcTrap;
    end else if (redirect_valid) begin
      src = SrcRedirect;
    end else if (ras_take) begin
      src = SrcRas;
    end else if (handshake) begin
      src = SrcSeq;
    end

    pc_d = pc_q;
    unique case (src)
      SrcTrap:     pc_d = trap_pc & AlignMask;
      SrcRedirect: pc_d = redirect_pc & AlignMask;
      SrcRas:      pc_d = ras_top;
      SrcSeq:      pc_d = pc_seq;
      default:     pc_d = pc_q;
    endcase
  end

  // State, PC and RAS-hit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VECTOR;
      ras_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ras_hit_q <= (src == SrcRas);
    end
  end

  assign current_pc = pc_q;
  assign ras_hit    = ras_hit_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen. RAS-dependent expectations follow whether
// PC_GEN_RAS_EN is defined for the build.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  localparam logic [31:0] RV = 32'h8000_0000;

  typedef struct {
    logic        stall;
    logic        tv;
    logic [31:0] tpc;
    logic        rv;
    logic [31:0] rpc;
    logic        call;
    logic        ret;
    logic        ready;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_hit;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        hit;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        pred_call = 1'b0;
  logic        pred_ret = 1'b0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [31:0] current_pc;
  logic        ras_hit;

  int   n_checks = 0;
  int   n_fail = 0;
  int   tag_cnt = 0;
  exp_t sb[$];
  vec_t tbl[17];

  pc_gen dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pred_call      (pred_call),
    .pred_ret       (pred_ret),
    .req_ready      (req_ready),
    .req_valid      (req_valid),
    .current_pc     (current_pc),
    .ras_hit        (ras_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic s, logic tv, logic [31:0] tpc, logic rv, logic [31:0] rpc,
                              logic c, logic r, logic rdy, logic [31:0] epc, logic ev,
                              logic eh);
    vec_t v;
    v.stall = s;  v.tv = tv;  v.tpc = tpc;  v.rv = rv;  v.rpc = rpc;
    v.call = c;   v.ret = r;  v.ready = rdy;
    v.exp_pc = epc;  v.exp_valid = ev;  v.exp_hit = eh;
    return v;
  endfunction

  task automatic expect_now(logic [31:0] pc, logic valid, logic hit);
    exp_t e;
    e.pc = pc;  e.valid = valid;  e.hit = hit;  e.tag = tag_cnt;
    tag_cnt++;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (current_pc !== e.pc) begin
      n_fail++;
      $display("FAIL pc[%0d]: got %h expected %h", e.tag, current_pc, e.pc);
    end
    n_checks++;
    if (req_valid !== e.valid) begin
      n_fail++;
      $display("FAIL req_valid[%0d]: got %b expected %b", e.tag, req_valid, e.valid);
    end
    n_checks++;
    if (ras_hit !== e.hit) begin
      n_fail++;
      $display("FAIL ras_hit[%0d]: got %b expected %b", e.tag, ras_hit, e.hit);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check mid-low-phase, then
  // let the rising edge pass and return at the next falling edge.
  task automatic apply(vec_t v);
    stall          = v.stall;
    trap_valid     = v.tv;
    trap_pc        = v.tpc;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    pred_call      = v.call;
    pred_ret       = v.ret;
    req_ready      = v.ready;
    expect_now(v.exp_pc, v.exp_valid, v.exp_hit);
    #2;
    check_now();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc_e;
    logic        hit_e;
    logic [31:0] a;

    // Boot, sequential fetch, backpressure, stall, priority clash, alignment, wrap.
    //             stall tv  tpc           rv  rpc           cl  rt  rdy exp_pc        v    h
    tbl[0]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, RV,            1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, RV,            1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8000_0004, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8000_000C, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0010, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0010, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0010, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8000_0010, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8000_0014, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 32'h100,      1'b1, 32'h200,      1'b0, 1'b0, 1'b1, 32'h8000_0014, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h203,      1'b0, 1'b0, 1'b1, 32'h100,       1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 32'h107,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200,       1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'h104,      1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
    tbl[16] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0020, 1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 1'b0);

    // Values while reset is held, with the memory ready.
    req_ready = 1'b1;
    #12;
    expect_now(RV, 1'b0, 1'b0);
    check_now();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) apply(tbl[i]);

    // Call, redirect (with a suppressed return), then a return via the RAS.
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h8000_0020, 1'b1, 1'b0));
    apply(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h9000, 1'b0, 1'b1, 1'b1, 32'h8000_0024, 1'b1, 1'b0));
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h9000,      1'b1, 1'b0));
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1,
             RasEn ? 32'h8000_0024 : 32'h9004, 1'b1, RasEn));
    apply(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b1,
             RasEn ? 32'h8000_0028 : 32'h9008, 1'b1, 1'b0));

    // A trap empties the stack: the following return is sequential.
    apply(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h4000, 1'b1, 1'b0));
    apply(mk(1'b1, 1'b1, 32'h100, 1'b1, 32'h200,  1'b0, 1'b0, 1'b1, 32'h4004, 1'b0, 1'b0));
    apply(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h100,  1'b1, 1'b0));
    apply(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000, 1'b0, 1'b0, 1'b1, 32'h104,  1'b1, 1'b0));

    // Overflow: five calls from distinct sites, each followed by a redirect.
    for (int i = 0; i < 5; i++) begin
      a = 32'h1000 * (i + 1);
      apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a, 1'b1, 1'b0));
      apply(mk(1'b0, 1'b0, 32'h0, 1'b1, (i < 4) ? a + 32'h1000 : 32'h7000,
               1'b0, 1'b0, 1'b1, a + 32'h4, 1'b1, 1'b0));
    end

    // Five returns: the newest four come back LIFO, the last is sequential.
    pc_e  = 32'h7000;
    hit_e = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, pc_e, 1'b1, hit_e));
      if (RasEn && k < 4) begin
        pc_e  = 32'h5004 - 32'h1000 * k;
        hit_e = 1'b1;
      end else begin
        pc_e  = pc_e + 32'h4;
        hit_e = 1'b0;
      end
    end
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc_e, 1'b1, hit_e));

    // Reset asserted mid-cycle with a trap pending, then a clean reboot.
    trap_valid = 1'b1;
    trap_pc    = 32'h300;
    req_ready  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    expect_now(RV, 1'b0, 1'b0);
    check_now();
    @(negedge clk);
    trap_valid = 1'b0;
    reset      = 1'b0;
    for (int i = 0; i < 3; i++) apply(tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
